// File: rtl/rle_line_decoder_if.sv
// ============================================================================
// rle_line_decoder_if : run-length line in, pixel stream and run bounds out
// Rev 1.0
// ============================================================================
`default_nettype none

interface rle_line_decoder_if;
   logic [9:0]  stream1;
   logic [9:0]  stream2;
   logic        line_load;
   logic        pix_ready;
   logic        pixelout;
   logic        pix_valid;
   logic        line_done;
   logic        overrun;
   logic [10:0] white_start;
   logic [10:0] white_end;
   logic [10:0] centre_col;
   logic        centre_valid;

   modport master (
      output stream1, stream2, line_load, pix_ready,
      input  pixelout, pix_valid, line_done, overrun,
      input  white_start, white_end, centre_col, centre_valid
   );

   modport slave (
      input  stream1, stream2, line_load, pix_ready,
      output pixelout, pix_valid, line_done, overrun,
      output white_start, white_end, centre_col, centre_valid
   );
endinterface

`default_nettype wire

// File: rtl/rle_line_decoder.sv
// ============================================================================
// rle_line_decoder : expands (black run, white run) into IMAGE_W+1 pixels
// Rev 1.0
// ============================================================================
`default_nettype none

module rle_line_decoder #(
   parameter logic [10:0] IMAGE_W = 11'd639
) (
   input  logic              CLK,
   input  logic              RESET,
   rle_line_decoder_if.slave bus
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [11:0] c_IMAGE_W12 = {1'b0, IMAGE_W};

   state_t      r_state;
   logic [10:0] r_col;
   logic [10:0] r_a_s1, r_a_s2;
   logic [10:0] r_p_s1, r_p_s2;
   logic        r_p_full;
   logic        r_pixelout, r_pix_valid, r_line_done, r_overrun;
   logic [10:0] r_white_start, r_white_end, r_centre_col;
   logic        r_centre_valid;

   logic        w_accept, w_last, w_from_pend, w_from_in;
   logic [10:0] w_new_s1, w_new_s2;
   logic        w_vld;
   logic [11:0] w_end12, w_ctr12;
   logic [10:0] w_wend, w_wctr;

   // 12-bit end so a run reaching past column 2047 cannot wrap back to white
   function automatic logic f_pix(input logic [10:0] c, input logic [10:0] s1,
                                  input logic [10:0] s2);
      logic [11:0] run_end;
      run_end = {1'b0, s1} + {1'b0, s2};
      return (c >= s1) && ({1'b0, c} < run_end);
   endfunction

   always_comb begin
      w_accept    = r_pix_valid & bus.pix_ready;
      w_last      = w_accept && (r_col == IMAGE_W);
      w_from_pend = w_last && r_p_full;
      w_from_in   = bus.line_load && ((r_state == ST_IDLE) || (w_last && !r_p_full));
      w_new_s1    = w_from_pend ? r_p_s1 : {1'b0, bus.stream1};
      w_new_s2    = w_from_pend ? r_p_s2 : {1'b0, bus.stream2};
      w_vld       = (w_new_s2 != 11'd0) && (w_new_s1 <= IMAGE_W);
      w_end12     = {1'b0, w_new_s1} + {1'b0, w_new_s2} - 12'd1;
      w_ctr12     = {1'b0, w_new_s1} + {2'b00, w_new_s2[10:1]};
      w_wend      = (w_end12 > c_IMAGE_W12) ? IMAGE_W : w_end12[10:0];
      w_wctr      = (w_ctr12 > c_IMAGE_W12) ? IMAGE_W : w_ctr12[10:0];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state        <= ST_IDLE;
         r_col          <= 11'd0;
         r_a_s1         <= 11'd0;
         r_a_s2         <= 11'd0;
         r_p_s1         <= 11'd0;
         r_p_s2         <= 11'd0;
         r_p_full       <= 1'b0;
         r_pixelout     <= 1'b0;
         r_pix_valid    <= 1'b0;
         r_line_done    <= 1'b0;
         r_overrun      <= 1'b0;
         r_white_start  <= 11'd0;
         r_white_end    <= 11'd0;
         r_centre_col   <= 11'd0;
         r_centre_valid <= 1'b0;
      end else begin
         r_line_done <= w_last;
         r_overrun   <= 1'b0;

         if (w_from_pend || w_from_in) begin
            r_state        <= ST_ACTIVE;
            r_a_s1         <= w_new_s1;
            r_a_s2         <= w_new_s2;
            r_col          <= 11'd0;
            r_pix_valid    <= 1'b1;
            r_pixelout     <= f_pix(11'd0, w_new_s1, w_new_s2);
            r_centre_valid <= w_vld;
            r_white_start  <= w_vld ? w_new_s1 : 11'd0;
            r_white_end    <= w_vld ? w_wend : 11'd0;
            r_centre_col   <= w_vld ? w_wctr : 11'd0;
         end else if (w_last) begin
            r_state     <= ST_IDLE;
            r_col       <= 11'd0;
            r_pix_valid <= 1'b0;
            r_pixelout  <= 1'b0;
         end else if (w_accept) begin
            r_col      <= r_col + 11'd1;
            r_pixelout <= f_pix(r_col + 11'd1, r_a_s1, r_a_s2);
         end

         if (w_from_pend)
            r_p_full <= 1'b0;
         // A load that is not taken straight into the active slot parks in pending
         if ((r_state == ST_ACTIVE) && bus.line_load && !w_from_in) begin
            r_p_s1    <= {1'b0, bus.stream1};
            r_p_s2    <= {1'b0, bus.stream2};
            r_p_full  <= 1'b1;
            r_overrun <= r_p_full && !w_last;
         end
      end
   end

   assign bus.pixelout     = r_pixelout;
   assign bus.pix_valid    = r_pix_valid;
   assign bus.line_done    = r_line_done;
   assign bus.overrun      = r_overrun;
   assign bus.white_start  = r_white_start;
   assign bus.white_end    = r_white_end;
   assign bus.centre_col   = r_centre_col;
   assign bus.centre_valid = r_centre_valid;

endmodule

`default_nettype wire

// File: tb/tb_rle_line_decoder.sv
// ============================================================================
// tb_rle_line_decoder : scenario tasks checked against a run-length line model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rle_line_decoder;
   localparam int W = 640;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   rle_line_decoder_if bus ();

   rle_line_decoder #(.IMAGE_W(11'd639)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // capture results
   bit cap[$];
   int done_cyc[$];
   int first_valid_cyc;
   int ovr_cnt;
   int hold_err;
   bit tmo;
   int sched_col[$];
   int sched_s1[$];
   int sched_s2[$];

   function automatic bit model_pix(int c, int s1, int s2);
      return (c >= s1) && (c < s1 + s2) && (c < W);
   endfunction

   function automatic void model_bounds(input int s1, input int s2, output int ws,
                                        output int we, output int cc, output int cv);
      cv = (s2 != 0 && s1 <= W - 1) ? 1 : 0;
      ws = cv ? s1 : 0;
      we = cv ? ((s1 + s2 - 1 > W - 1) ? W - 1 : s1 + s2 - 1) : 0;
      cc = cv ? ((s1 + s2 / 2 > W - 1) ? W - 1 : s1 + s2 / 2) : 0;
   endfunction

   // number of captured pixels in [off, off+W) disagreeing with the model line
   function automatic int line_diffs(int off, int s1, int s2);
      int d = 0;
      if (cap.size() < off + W) return W;
      for (int i = 0; i < W; i++)
         if (cap[off + i] !== model_pix(i, s1, s2)) d++;
      return d;
   endfunction

   task automatic do_load(input int s1, input int s2);
      bus.stream1   = 10'(s1);
      bus.stream2   = 10'(s2);
      bus.line_load = 1'b1;
      @(posedge CLK); #1;
      bus.line_load = 1'b0;
   endtask

   // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready
   task automatic capture(input int mode, input int n_done, input int max_cyc,
                          input int stop_acc);
      int k = 0, nacc = 0, phase = 0;
      bit r, pv_prev = 0, pr_prev = 0, px_prev = 0;
      cap.delete(); done_cyc.delete();
      ovr_cnt = 0; hold_err = 0; tmo = 0; first_valid_cyc = -1;
      while (done_cyc.size() < n_done) begin
         if (stop_acc > 0 && cap.size() >= stop_acc) break;
         if (k >= max_cyc) begin tmo = 1; break; end
         if (bus.line_done) done_cyc.push_back(cyc);
         if (bus.overrun) ovr_cnt++;
         if (bus.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (pv_prev && !pr_prev && (!bus.pix_valid || bus.pixelout !== px_prev)) hold_err++;
         if (done_cyc.size() >= n_done) break;
         case (mode)
            0:       r = 1'b1;
            1:       r = (phase % 4 == 0) || (phase % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         phase++;
         bus.pix_ready = r;
         bus.line_load = 1'b0;
         if (bus.pix_valid && sched_col.size() > 0 && nacc == sched_col[0]) begin
            void'(sched_col.pop_front());
            bus.stream1   = 10'(sched_s1.pop_front());
            bus.stream2   = 10'(sched_s2.pop_front());
            bus.line_load = 1'b1;
         end
         if (bus.pix_valid && r) begin
            cap.push_back(bus.pixelout);
            nacc = (nacc == W - 1) ? 0 : nacc + 1;
         end
         pv_prev = bus.pix_valid; pr_prev = r; px_prev = bus.pixelout;
         @(posedge CLK); #1;
         k++;
      end
      bus.line_load = 1'b0;
      bus.pix_ready = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; bus.line_load = 1'b1; bus.pix_ready = 1'b1;
      bus.stream1 = 10'd5; bus.stream2 = 10'd5;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if ({bus.pix_valid, bus.pixelout, bus.line_done, bus.overrun, bus.centre_valid} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b expected 00000",
            {bus.pix_valid, bus.pixelout, bus.line_done, bus.overrun, bus.centre_valid});
      end
      checks++; if ({bus.white_start, bus.white_end, bus.centre_col} !== 33'd0) begin
         errors++; $display("FAIL reset_bounds got %0d/%0d/%0d expected 0/0/0",
            bus.white_start, bus.white_end, bus.centre_col);
      end
      RESET = 1'b0; bus.line_load = 1'b0; bus.pix_ready = 1'b0;
      @(posedge CLK); #1;
      checks++; if (bus.pix_valid !== 1'b0) begin
         errors++; $display("FAIL reset_priority pix_valid got %b expected 0", bus.pix_valid);
      end
   endtask

   task automatic test_basic();
      int d;
      do_load(100, 50);
      checks++; if (bus.pix_valid !== 1'b1 || bus.pixelout !== 1'b0) begin
         errors++; $display("FAIL basic_first valid/pix got %b%b expected 10", bus.pix_valid, bus.pixelout);
      end
      checks++; if (bus.white_start !== 11'd100 || bus.white_end !== 11'd149 ||
                    bus.centre_col !== 11'd125 || bus.centre_valid !== 1'b1) begin
         errors++; $display("FAIL basic_bounds got %0d/%0d/%0d/%b expected 100/149/125/1",
            bus.white_start, bus.white_end, bus.centre_col, bus.centre_valid);
      end
      capture(0, 1, 2000, 0);
      d = line_diffs(0, 100, 50);
      checks++; if (tmo || cap.size() != W || d != 0) begin
         errors++; $display("FAIL basic_line got %0d pixels, %0d wrong (timeout %b) expected 640, 0", cap.size(), d, tmo);
      end
      checks++; if (done_cyc.size() != 1 || done_cyc[0] - first_valid_cyc != W) begin
         errors++; $display("FAIL basic_done_latency got %0d expected 640",
            (done_cyc.size() > 0) ? done_cyc[0] - first_valid_cyc : -1);
      end
      checks++; if (bus.pix_valid !== 1'b0) begin
         errors++; $display("FAIL basic_idle_after pix_valid got %b expected 0", bus.pix_valid);
      end
   endtask

   task automatic test_black();
      int d;
      do_load(639, 0);
      checks++; if ({bus.white_start, bus.white_end, bus.centre_col, bus.centre_valid} !== 34'd0) begin
         errors++; $display("FAIL black_bounds got %0d/%0d/%0d/%b expected 0/0/0/0",
            bus.white_start, bus.white_end, bus.centre_col, bus.centre_valid);
      end
      capture(0, 1, 2000, 0);
      d = line_diffs(0, 639, 0);
      checks++; if (tmo || cap.size() != W || d != 0) begin
         errors++; $display("FAIL black_line got %0d pixels, %0d wrong expected 640, 0", cap.size(), d);
      end
   endtask

   task automatic test_truncation();
      int d;
      do_load(600, 100);
      checks++; if (bus.white_start !== 11'd600 || bus.white_end !== 11'd639 ||
                    bus.centre_col !== 11'd639 || bus.centre_valid !== 1'b1) begin
         errors++; $display("FAIL trunc_bounds got %0d/%0d/%0d/%b expected 600/639/639/1",
            bus.white_start, bus.white_end, bus.centre_col, bus.centre_valid);
      end
      capture(0, 1, 2000, 0);
      d = line_diffs(0, 600, 100);
      checks++; if (tmo || cap.size() != W || d != 0 || bus.pix_valid !== 1'b0) begin
         errors++; $display("FAIL trunc_line got %0d pixels, %0d wrong, valid %b expected 640, 0, 0",
            cap.size(), d, bus.pix_valid);
      end
   endtask

   task automatic test_backpressure();
      int d;
      do_load(100, 50);
      capture(1, 1, 4000, 0);
      d = line_diffs(0, 100, 50);
      checks++; if (tmo || cap.size() != W || d != 0) begin
         errors++; $display("FAIL bp_line got %0d pixels, %0d wrong expected 640, 0", cap.size(), d);
      end
      checks++; if (hold_err != 0) begin
         errors++; $display("FAIL bp_hold got %0d violations expected 0", hold_err);
      end
   endtask

   task automatic test_random();
      int s1, s2, ws, we, cc, cv, d;
      for (int n = 0; n < 5; n++) begin
         s1 = $urandom_range(0, 700);
         s2 = $urandom_range(0, 1023);
         model_bounds(s1, s2, ws, we, cc, cv);
         do_load(s1, s2);
         checks++; if (bus.white_start !== 11'(ws) || bus.white_end !== 11'(we) ||
                       bus.centre_col !== 11'(cc) || bus.centre_valid !== 1'(cv)) begin
            errors++; $display("FAIL rand_bounds s1=%0d s2=%0d got %0d/%0d/%0d/%b expected %0d/%0d/%0d/%0d",
               s1, s2, bus.white_start, bus.white_end, bus.centre_col, bus.centre_valid, ws, we, cc, cv);
         end
         capture(2, 1, 6000, 0);
         d = line_diffs(0, s1, s2);
         checks++; if (tmo || cap.size() != W || d != 0 || hold_err != 0) begin
            errors++; $display("FAIL rand_line s1=%0d s2=%0d got %0d pixels, %0d wrong, %0d hold errs expected 640, 0, 0",
               s1, s2, cap.size(), d, hold_err);
         end
      end
   endtask

   task automatic test_queueing();
      int da, dc;
      sched_col = '{300, 500}; sched_s1 = '{300, 0}; sched_s2 = '{20, 639};
      do_load(50, 200);
      capture(0, 2, 4000, 0);
      da = line_diffs(0, 50, 200);
      dc = line_diffs(W, 0, 639);
      checks++; if (ovr_cnt != 1) begin
         errors++; $display("FAIL queue_overrun got %0d pulses expected 1", ovr_cnt);
      end
      checks++; if (tmo || cap.size() != 2 * W || da != 0 || dc != 0) begin
         errors++; $display("FAIL queue_lines got %0d pixels, A %0d wrong, C %0d wrong expected 1280, 0, 0",
            cap.size(), da, dc);
      end
      checks++; if (done_cyc.size() != 2 || done_cyc[1] - done_cyc[0] != W || bus.pix_valid !== 1'b0) begin
         errors++; $display("FAIL queue_gap got %0d done pulses, valid %b expected 2 pulses 640 apart, valid 0",
            done_cyc.size(), bus.pix_valid);
      end
   endtask

   task automatic test_back_to_back();
      int da, db, dc;
      // pending B plus a load in A's last-accept cycle: A, B, C all emitted
      sched_col = '{10, 639}; sched_s1 = '{20, 30}; sched_s2 = '{20, 30};
      do_load(10, 10);
      capture(0, 3, 4000, 0);
      da = line_diffs(0, 10, 10);
      db = line_diffs(W, 20, 20);
      dc = line_diffs(2 * W, 30, 30);
      checks++; if (tmo || cap.size() != 3 * W || da + db + dc != 0 || ovr_cnt != 0) begin
         errors++; $display("FAIL b2b_three got %0d pixels, %0d wrong, %0d overruns expected 1920, 0, 0",
            cap.size(), da + db + dc, ovr_cnt);
      end
      checks++; if (done_cyc.size() != 3 || done_cyc[1] - done_cyc[0] != W || done_cyc[2] - done_cyc[1] != W) begin
         errors++; $display("FAIL b2b_gap got %0d done pulses expected 3 pulses 640 apart", done_cyc.size());
      end
      // nothing pending, load in last-accept cycle goes straight to active
      sched_col = '{639}; sched_s1 = '{620}; sched_s2 = '{19};
      do_load(5, 600);
      capture(0, 2, 4000, 0);
      da = line_diffs(0, 5, 600);
      db = line_diffs(W, 620, 19);
      checks++; if (tmo || cap.size() != 2 * W || da + db != 0 || done_cyc.size() != 2 ||
                    done_cyc[1] - done_cyc[0] != W) begin
         errors++; $display("FAIL b2b_direct got %0d pixels, %0d wrong, %0d dones expected 1280, 0, 2",
            cap.size(), da + db, done_cyc.size());
      end
   endtask

   task automatic test_reset_midline();
      int bad = 0, d;
      sched_col = '{100}; sched_s1 = '{0}; sched_s2 = '{639};
      do_load(200, 100);
      capture(0, 1, 2000, 320);
      RESET = 1'b1; bus.line_load = 1'b1; bus.pix_ready = 1'b1;
      bus.stream1 = 10'd1; bus.stream2 = 10'd1;
      @(posedge CLK); #1;
      RESET = 1'b0; bus.line_load = 1'b0; bus.pix_ready = 1'b1;
      checks++; if ({bus.pix_valid, bus.pixelout, bus.line_done, bus.overrun, bus.centre_valid} !== 5'b0 ||
                    {bus.white_start, bus.white_end, bus.centre_col} !== 33'd0) begin
         errors++; $display("FAIL midreset_outputs got flags %b bounds %0d/%0d/%0d expected 00000 0/0/0",
            {bus.pix_valid, bus.pixelout, bus.line_done, bus.overrun, bus.centre_valid},
            bus.white_start, bus.white_end, bus.centre_col);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         if (bus.pix_valid || bus.line_done) bad++;
      end
      checks++; if (bad != 0) begin
         errors++; $display("FAIL midreset_quiet got %0d active cycles expected 0", bad);
      end
      bus.pix_ready = 1'b0;
      do_load(0, 5);
      checks++; if (bus.pix_valid !== 1'b1 || bus.pixelout !== 1'b1 || bus.white_end !== 11'd4 ||
                    bus.centre_col !== 11'd2) begin
         errors++; $display("FAIL midreset_restart got valid %b pix %b end %0d ctr %0d expected 1 1 4 2",
            bus.pix_valid, bus.pixelout, bus.white_end, bus.centre_col);
      end
      capture(0, 1, 2000, 0);
      d = line_diffs(0, 0, 5);
      checks++; if (tmo || cap.size() != W || d != 0 || bus.pix_valid !== 1'b0) begin
         errors++; $display("FAIL midreset_line got %0d pixels, %0d wrong, valid %b expected 640, 0, 0",
            cap.size(), d, bus.pix_valid);
      end
   endtask

   initial begin
      bus.stream1 = 10'd0; bus.stream2 = 10'd0;
      bus.line_load = 1'b0; bus.pix_ready = 1'b0;
      test_reset();
      test_basic();
      test_black();
      test_truncation();
      test_backpressure();
      test_random();
      test_queueing();
      test_back_to_back();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/rle_line_decoder.md
# rle_line_decoder

Expands one line of run-length data (leading black run, white run) into a 1-bit pixel stream of `IMAGE_W+1` pixels for the VIP overlay and mask-display path. It is the inverse of the per-line RLE encoder: it consumes that encoder's `stream1`/`stream2` pair on each end-of-line strobe and regenerates the filtered mask column by column. A one-line pending buffer accepts the next line while the current line is still being emitted. It also reports the white run's bounds and centre column for steering logic.

## Interface
- `IMAGE_W`, 11'd639: index of the last column; each line is `IMAGE_W+1` pixels.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `stream1` in 10: leading black run length, which is also the white start column.
- `stream2` in 10: white run length; 0 means an all-black line.
- `line_load` in 1: one-cycle strobe; `stream1`/`stream2` are sampled in the cycle it is high. It is driven by the encoder's `im_end`.
- `pix_ready` in 1: the downstream consumer accepts the pixel when this and `pix_valid` are both high.
- `pixelout` out 1: current pixel, 1 = white.
- `pix_valid` out 1: `pixelout` is valid.
- `line_done` out 1: one-cycle pulse after the last pixel of a line is accepted.
- `overrun` out 1: one-cycle pulse when a pending line is overwritten.
- `white_start` out 11: first white column of the active line.
- `white_end` out 11: last white column of the active line, clamped.
- `centre_col` out 11: centre column of the white run.
- `centre_valid` out 1: high while the active line has `stream2 != 0`.

## Operation
- **States:** IDLE and ACTIVE.
- **Registers:**
  - Active line: `a_s1` (11 bit, zero-extended) and `a_s2` (11 bit).
  - Pending line: `p_s1`, `p_s2` and a `p_full` flag.
  - 11-bit column counter `col`.
- **Pixel rule:**
  - `pixelout = (col >= a_s1) && (col < a_s1 + a_s2)`, computed with an 12-bit sum so there is no wrap.
  - Columns beyond `IMAGE_W` are never emitted, so white runs extending past the line end are truncated.
  - If `a_s1 > IMAGE_W`, the whole line is black.
- **Bounds, registered when a line becomes active:**
  - `white_start = a_s1`.
  - `white_end = min(a_s1 + a_s2 - 1, IMAGE_W)`.
  - `centre_col = min(a_s1 + (a_s2 >> 1), IMAGE_W)`.
  - `centre_valid = (a_s2 != 0) && (a_s1 <= IMAGE_W)`.
  - When `centre_valid` is 0, `white_start`, `white_end` and `centre_col` are 0.
  - All four hold until the next line becomes active.
- **IDLE:**
  - On `line_load`, the inputs load into the active registers and `col` is set to 0.
  - The state goes to ACTIVE.
- **ACTIVE:**
  - `pix_valid` = 1.
  - On accept (`pix_valid & pix_ready`) with `col < IMAGE_W`, `col` increments.
  - `pixelout`, `pix_valid` and `col` hold while `pix_ready` is low.
- **Last accept** (accept with `col == IMAGE_W`):
  - `line_done` pulses in the next cycle.
  - If `p_full` is set, the pending line moves to active, `col` is set to 0, `p_full` clears and the state stays ACTIVE. Back-to-back lines have no bubble.
  - Else, if `line_load` is high in the same cycle, the inputs go straight to active and the state stays ACTIVE.
  - Otherwise the state goes to IDLE.
- **`line_load` while ACTIVE, not the last-accept cycle:**
  - The inputs go to pending and `p_full` is set.
  - If `p_full` was already set, the pending line is overwritten (newest wins) and `overrun` pulses next cycle.
- **`line_load` in the last-accept cycle with `p_full` set:**
  - The old pending line becomes active.
  - The new line goes to pending and `p_full` stays set. There is no overrun.
- **Reset:** any line in progress is abandoned with no `line_done`, and the pending line is discarded.

## Timing
- **Reset values:**
  - State IDLE, `col` = 0, `p_full` = 0.
  - `pixelout`, `pix_valid`, `line_done`, `overrun`, `centre_valid` = 0.
  - `white_start`, `white_end`, `centre_col` = 0.
- **Reset priority:** `RESET` overrides `line_load` and `pix_ready` in the same cycle.
- **Latency:**
  - `line_load` at cycle t in IDLE gives `pix_valid = 1` with column 0 at t+1.
  - Bounds and `centre_valid` are valid at t+1.
- **Throughput:** one pixel per cycle with `pix_ready` held high. A line takes `IMAGE_W+1` cycles.
- **Line end:** `line_done` pulses at the cycle after the last accept. This is the same cycle the next line's column 0 appears, if one is queued.
- **Outputs:** all outputs are registered.
- **Pixel timing:** `pixelout` reflects the current `col`.

## Test plan
- **Basic line:**
  - Stimulus: IDLE, `line_load` with `stream1`=100, `stream2`=50, `pix_ready`=1.
  - Pixels 0–99 are 0, 100–149 are 1 and 150–639 are 0.
  - `white_start`=100, `white_end`=149, `centre_col`=125, `centre_valid`=1.
  - `line_done` pulses exactly 640 cycles after the first `pix_valid`.
- **Black line:**
  - Stimulus: `stream1`=639, `stream2`=0.
  - All 640 pixels are 0, `centre_valid`=0 and bounds are 0.
- **Truncation:**
  - Stimulus: `stream1`=600, `stream2`=100.
  - Pixels 600–639 are 1, `white_end`=639, `centre_col`=639.
  - There is no 641st pixel.
- **Back-pressure:**
  - Stimulus: `pix_ready` toggles 1,0,0,1 repeatedly.
  - `pixelout` and `col` are held while `pix_ready` is low.
  - The decoded pattern is identical to the basic line case.
- **Queueing:**
  - Stimulus: `line_load` A at column 10, B at column 300, C at column 500.
  - `overrun` pulses once, at C.
  - Line C follows A with no gap cycle, and B is never emitted.
- **Reset mid-line:**
  - Stimulus: `RESET` at column 320 with `p_full` set.
  - Next cycle: `pix_valid`=0, all outputs are at their reset values and there is no `line_done`.
  - A new `line_load` starts at column 0.
